// File: rtl/ram_burst_reader_if.sv
// Valid/ready beat stream carrying burst read data out of ram_burst_reader.
interface ram_burst_reader_if #(
  parameter int MEM_WIDTH_DATA = 8
);
  logic                      m_valid;
  logic [MEM_WIDTH_DATA-1:0] m_data;
  logic                      m_last;
  logic                      m_ready;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/ram_burst_reader.sv
// Initiator for the single-port parameter RAM: streams (base, len) bursts onto a
// valid/ready port through a 2-entry buffer; passes host load writes while idle.
module ram_burst_reader #(
  parameter int MEM_WIDTH_DATA = 8,
  parameter int MEM_DEPTH      = 256,
  parameter int WIDTH_MEM_ADDR = 8,
  parameter int WIDTH_LEN      = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH_MEM_ADDR-1:0] base_addr,
  input  logic [WIDTH_LEN-1:0]      burst_len,
  input  logic                      wr_en,
  input  logic [WIDTH_MEM_ADDR-1:0] wr_addr,
  input  logic [MEM_WIDTH_DATA-1:0] wr_data,
  output logic                      ram_wea,
  output logic [WIDTH_MEM_ADDR-1:0] ram_addr,
  output logic [MEM_WIDTH_DATA-1:0] ram_data_in,
  input  logic [MEM_WIDTH_DATA-1:0] ram_data_out,
  ram_burst_reader_if.master        strm,
  output logic                      busy,
  output logic                      done,
  output logic                      wr_drop
);
  // state | meaning
  // IDLE  | host owns the RAM pins; start/burst_len sampled
  // READ  | issuing reads while issue_left > 0
  // DRAIN | all reads issued; waiting for the last beat handshake
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [WIDTH_MEM_ADDR-1:0] LAST_ADDR = WIDTH_MEM_ADDR'(MEM_DEPTH - 1);

  state_t                    state, state_nxt;
  logic [WIDTH_MEM_ADDR-1:0] rd_ptr;
  logic [WIDTH_LEN-1:0]      issue_left, beat_left;
  logic                      inflight;
  logic [MEM_WIDTH_DATA-1:0] buf_mem [2];
  logic                      buf_rd, buf_wr;
  logic [1:0]                buf_count, occ_after;
  logic                      pop, push, issue, accept, zero_req, last_pop;

  assign pop       = strm.m_valid & strm.m_ready;
  assign push      = inflight;
  assign occ_after = buf_count + {1'b0, inflight} - {1'b0, pop};
  assign last_pop  = pop & (beat_left == WIDTH_LEN'(1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    accept    = 1'b0;
    zero_req  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            accept    = 1'b1;
            state_nxt = READ;
          end else begin
            zero_req = 1'b1;
          end
        end
      end
      READ: begin
        // Counting the in-flight read keeps the buffer from ever overflowing.
        if ((issue_left != '0) && (occ_after < 2'd2)) begin
          issue = 1'b1;
          if (issue_left == WIDTH_LEN'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_wea     = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    if (rst_n) begin
      if (state == IDLE) begin
        ram_wea     = wr_en;
        ram_addr    = wr_addr;
        ram_data_in = wr_data;
      end else begin
        ram_addr = rd_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      issue_left <= '0;
      beat_left  <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        rd_ptr     <= base_addr;
        issue_left <= burst_len;
        beat_left  <= burst_len;
      end else begin
        if (issue) begin
          rd_ptr     <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + WIDTH_MEM_ADDR'(1);
          issue_left <= issue_left - WIDTH_LEN'(1);
        end
        if (pop) beat_left <= beat_left - WIDTH_LEN'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[buf_wr] <= ram_data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_rd    <= 1'b0;
      buf_wr    <= 1'b0;
      buf_count <= '0;
    end else begin
      if (push) buf_wr <= ~buf_wr;
      if (pop)  buf_rd <= ~buf_rd;
      buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      done    <= zero_req | ((state == DRAIN) & last_pop);
      wr_drop <= wr_en & busy;
    end
  end

  assign strm.m_valid = (buf_count != '0);
  assign strm.m_data  = buf_mem[buf_rd];
  assign strm.m_last  = strm.m_valid & (beat_left == WIDTH_LEN'(1));

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (buf_count == 2'd2)));
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural RAM and a beat scoreboard.
module tb_ram_burst_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] burst_len = '0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       ram_wea;
  logic [7:0] ram_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;
  logic       busy, done, wr_drop;

  logic [7:0] ram_mem   [256];
  logic [7:0] model_mem [256];
  logic [8:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  ram_burst_reader_if #(.MEM_WIDTH_DATA(8)) strm ();

  ram_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .strm(strm), .busy(busy), .done(done),
    .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wea) ram_mem[ram_addr] <= ram_data_in;
    ram_data_out <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop plus hold-stability tracking under backpressure.
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", strm.m_valid, 1);
        check("hold_data", strm.m_data, prev_data);
        check("hold_last", strm.m_last, prev_last);
      end
      if (strm.m_valid && strm.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(exp_q.size()), 1);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("beat_data", strm.m_data, e[7:0]);
          check("beat_last", strm.m_last, e[8]);
        end
      end
      hold_prev = strm.m_valid && !strm.m_ready;
      prev_data = strm.m_data;
      prev_last = strm.m_last;
    end
  end

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_burst(input logic [7:0] b, input logic [8:0] n);
    start = 1'b1; base_addr = b; burst_len = n;
    for (int i = 0; i < int'(n); i++) begin
      logic [7:0] a;
      a = b + 8'(i);
      exp_q.push_back({(i == int'(n) - 1), model_mem[a]});
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check(tag, found, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    strm.m_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 8'h33; wr_data = 8'h77;
    #12;
    check("rst_valid", strm.m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wea", ram_wea, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wr_drop", wr_drop, 0);
    wr_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload
    for (int i = 0; i < 4; i++) host_write(8'(10 + i), 8'(8'hA0 + i));
    for (int i = 4; i < 8; i++) host_write(8'(10 + i), 8'(8'hB0 + i));
    for (int i = 0; i < 6; i++) host_write(8'(20 + i), 8'($urandom_range(0, 255)));
    host_write(8'd254, 8'hC0); host_write(8'd255, 8'hC1);
    host_write(8'd0, 8'hC2);   host_write(8'd1, 8'hC3);
    host_write(8'd5, 8'h55);

    // Burst order and cycle timing
    start_burst(8'd10, 9'd4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("t1_valid_c%0d", k), strm.m_valid, (k >= 3 && k <= 6));
      check($sformatf("t1_last_c%0d", k), strm.m_last, (k == 6));
      check($sformatf("t1_done_c%0d", k), done, (k == 7));
      check($sformatf("t1_busy_c%0d", k), busy, (k <= 6));
    end
    @(posedge clk); #1;
    check("t1_sb_empty", 32'(exp_q.size()), 0);

    // Backpressure
    start_burst(8'd20, 9'd6);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      strm.m_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      if (done) found = 1'b1;
      @(posedge clk); #1;
    end
    strm.m_ready = 1'b1;
    check("bp_done", found, 1);
    check("bp_sb_empty", 32'(exp_q.size()), 0);

    // Wrap-around addressing
    start_burst(8'd254, 9'd4);
    for (int k = 1; k <= 4; k++) begin
      logic [7:0] ea;
      ea = 8'(253 + k);
      @(negedge clk);
      check($sformatf("wrap_addr_c%0d", k), ram_addr, ea);
    end
    @(posedge clk); #1;
    wait_done("wrap_done", 20);
    check("wrap_sb_empty", 32'(exp_q.size()), 0);

    // Zero-length burst
    @(negedge clk);
    check("zl_busy_before", busy, 0);
    @(posedge clk); #1;
    start_burst(8'd10, 9'd0);
    @(negedge clk);
    check("zl_done", done, 1);
    check("zl_busy", busy, 0);
    check("zl_valid", strm.m_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("zl_done_clear", done, 0);
    check("zl_valid2", strm.m_valid, 0);
    @(posedge clk); #1;

    // Write while busy is dropped
    start_burst(8'd10, 9'd4);
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'hFF;
    @(negedge clk);
    check("wb_wea", ram_wea, 0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("wb_drop", wr_drop, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("wb_drop_clear", wr_drop, 0);
    @(posedge clk); #1;
    wait_done("wb_done", 20);
    start_burst(8'd5, 9'd1);
    wait_done("wb_readback_done", 20);
    check("wb_sb_empty", 32'(exp_q.size()), 0);

    // Mid-burst reset on the third beat
    start_burst(8'd10, 9'd8);
    repeat (4) @(posedge clk);
    #1;
    check("mr_valid_before", strm.m_valid, 1);
    check("mr_beats_left", 32'(exp_q.size()), 6);
    rst_n = 1'b0;
    #1;
    check("mr_valid", strm.m_valid, 0);
    check("mr_last", strm.m_last, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_wea", ram_wea, 0);
    check("mr_addr", ram_addr, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mr_no_done_%0d", k), done, 0);
      check($sformatf("mr_idle_%0d", k), busy, 0);
    end
    @(posedge clk); #1;
    start_burst(8'd10, 9'd2);
    wait_done("mr_fresh_done", 20);
    check("mr_sb_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Initiator-side controller for the single-port synchronous parameter RAM. It owns the RAM's address, write-enable and write-data pins. It turns a (base, length) request into a stream of read beats on a valid/ready output, absorbing the RAM's one-cycle read latency and downstream backpressure. While idle, it passes host load writes through to the RAM.

## Interface
- MEM_WIDTH_DATA, 8, RAM word width
- MEM_DEPTH, 256, RAM depth in words
- WIDTH_MEM_ADDR, 8, RAM address width
- WIDTH_LEN, 9, burst length width (must hold MEM_DEPTH)

- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  burst request, sampled only in IDLE
- base_addr  in  WIDTH_MEM_ADDR  first read address
- burst_len  in  WIDTH_LEN  number of words to read
- wr_en  in  1  host load write request
- wr_addr  in  WIDTH_MEM_ADDR  host write address
- wr_data  in  MEM_WIDTH_DATA  host write data
- ram_wea  out  1  to RAM write enable
- ram_addr  out  WIDTH_MEM_ADDR  to RAM address
- ram_data_in  out  MEM_WIDTH_DATA  to RAM write data
- ram_data_out  in  MEM_WIDTH_DATA  from RAM registered read data
- m_valid  out  1  output beat valid
- m_data  out  MEM_WIDTH_DATA  output beat data
- m_last  out  1  final beat of burst
- m_ready  in  1  downstream accept
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at burst completion
- wr_drop  out  1  one-cycle pulse when wr_en is ignored

## Operation
- States:
  - IDLE: start=1 and burst_len>0 → READ; latch base_addr into rd_ptr and burst_len into issue_left and beat_left.
  - IDLE: start=1 and burst_len=0 → stay in IDLE; done pulses next cycle.
  - READ: issue_left reaches 0 → DRAIN.
  - DRAIN: the beat with beat_left=1 is accepted → IDLE.
- Read issue in READ: issue when issue_left>0 and (buf_count + inflight − pop) < 2.
  - pop = m_valid & m_ready.
  - An issue drives ram_addr=rd_ptr, then increments rd_ptr and decrements issue_left.
- Addressing: rd_ptr wraps from MEM_DEPTH−1 to 0.
- Latency: inflight is set on an issue. The next cycle, ram_data_out is pushed into the 2-entry output buffer.
- Output: m_valid = buffer non-empty; m_data = buffer head; m_last = m_valid & (beat_left==1). Each pop decrements beat_left.
- Buffer overflow is impossible by construction. An overflow is an assertion failure.
- ram_addr mux:
  - IDLE: ram_addr=wr_addr, ram_wea=wr_en, ram_data_in=wr_data.
  - READ/DRAIN: ram_wea=0, ram_data_in=0; ram_addr=rd_ptr (held when not issuing).
- Ignored requests: wr_en while busy is dropped and wr_drop pulses the next cycle. start while busy is ignored.
- Reset (async, any time, including mid-burst):
  - State → IDLE; buffer, inflight, counters cleared.
  - All outputs 0 (ram_addr=wr_addr once released).
  - No done pulse for an aborted burst.

## Timing
- Cycle 0: start sampled. Cycle 1: first read issued. Cycle 2: RAM data captured into the buffer. Cycle 3: first m_valid.
- With m_ready held 1: one beat per cycle, so an N-word burst occupies m_valid for cycles 3..N+2.
- Completion: done pulses one cycle after the m_last handshake. busy falls in the same cycle done rises.
- m_data and m_last stay stable while m_valid=1 and m_ready=0.
- A new start is accepted in the cycle done is high, since the state is IDLE.
- The host write path has zero added latency: the RAM commits a write on the same edge wr_en is sampled in IDLE.

## Test plan
- Burst order: preload mem[10..13]=A0..A3 via wr_en. Then start with base=10, len=4, m_ready=1 → beats A0,A1,A2,A3 on cycles 3–6; m_last on A3; done at cycle 7.
- Backpressure: len=6 with m_ready toggled 1,0,0,1,… → data order preserved and no beat lost or duplicated. Buffer count never exceeds 2; held beats stay stable.
- Wrap-around: base=254, len=4 → reads addresses 254,255,0,1 in that order.
- Zero-length burst: start with len=0 → no m_valid, busy stays 0, done pulses one cycle later.
- Write while busy: wr_en=1 with wr_addr=5 during a burst → ram_wea stays 0 and wr_drop pulses. mem[5] is unchanged when read back afterwards.
- Mid-burst reset: assert rst_n=0 during the 3rd beat of a len=8 burst → outputs 0 immediately and no done. A fresh len=2 burst then returns correct data.
